// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage RISC-V pipeline: load-use interlock,
// MEM-stage branch flush, data-memory wait freeze with timeout trap, perf counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             mem_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;

    state_t     state_reg;
    logic [7:0] wait_cnt_reg;
    logic       mem_fault_reg;

    logic load_use;
    logic freeze;
    logic run_rules;
    logic in_fault;
    logic br_flush;
    logic lu_stall;
    logic [1:0] cnt_inc;

    assign load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    // Classify the current cycle; flags stay low while in reset.
    always_comb begin
        freeze    = 1'b0;
        run_rules = 1'b0;
        in_fault  = 1'b0;
        br_flush  = 1'b0;
        lu_stall  = 1'b0;
        if (rstn) begin
            unique case (state_reg)
                RUN: begin
                    if (dmem_req && !dmem_ready) freeze = 1'b1;
                    else                         run_rules = 1'b1;
                end
                MEM_WAIT: begin
                    if (!dmem_ready) freeze = 1'b1;
                    else             run_rules = 1'b1;
                end
                default: in_fault = 1'b1;
            endcase
            if (run_rules) begin
                // A taken branch squashes the younger instructions, so their load-use is moot.
                if (mem_branch_taken) br_flush = 1'b1;
                else if (load_use)    lu_stall = 1'b1;
            end
        end
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (!rstn) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (in_fault) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
        end else if (freeze) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (br_flush) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (lu_stall) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg     <= RUN;
            wait_cnt_reg  <= 8'd0;
            mem_fault_reg <= 1'b0;
        end else begin
            unique case (state_reg)
                RUN: begin
                    if (freeze) begin
                        state_reg    <= MEM_WAIT;
                        wait_cnt_reg <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state_reg    <= RUN;
                        wait_cnt_reg <= 8'd0;
                    end else if (wait_cnt_reg == 8'(MEM_TIMEOUT)) begin
                        state_reg     <= FAULT;
                        mem_fault_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                default: state_reg <= FAULT;
            endcase
        end
    end

    assign mem_fault = mem_fault_reg;

    // Index 0 counts stall cycles, index 1 counts taken-branch flushes.
    assign cnt_inc = {br_flush, freeze | lu_stall};

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;
        always_ff @(posedge clk) begin
            if (!rstn)
                cnt_reg <= '0;
            else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}}))
                cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign stall_cycles = g_cnt[0].cnt_reg;
    assign flush_count  = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: the driver queues hand-computed per-cycle expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_pipeline_hazard_ctrl;

    localparam int CW = 4;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_flush}
    localparam logic [7:0] C_RUN = 8'b1101_0100;
    localparam logic [7:0] C_LU  = 8'b0001_1100;
    localparam logic [7:0] C_BR  = 8'b1111_1110;
    localparam logic [7:0] C_FRZ = 8'b0000_0001;
    localparam logic [7:0] C_FLT = 8'b0000_0000;
    localparam logic [7:0] C_RST = 8'b0010_1011;

    logic clk = 1'b0;
    logic rstn;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_use_rs1, id_use_rs2, ex_memread, mem_branch_taken, dmem_req, dmem_ready;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_flush;
    logic mem_fault;
    logic [CW-1:0] stall_cycles, flush_count;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(CW)) dut (
        .clk(clk), .rstn(rstn),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .mem_branch_taken(mem_branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .mem_fault(mem_fault),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    typedef struct {
        string         nm;
        logic [7:0]    ctrl;
        logic          flt;
        logic [CW-1:0] st;
        logic [CW-1:0] fl;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int txn    = 0;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [7:0] act;
            e   = q.pop_front();
            act = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_flush};
            checks += 4;
            if (act !== e.ctrl) begin
                errors++;
                $display("FAIL %s ctrl: got %b want %b", e.nm, act, e.ctrl);
            end
            if (mem_fault !== e.flt) begin
                errors++;
                $display("FAIL %s mem_fault: got %b want %b", e.nm, mem_fault, e.flt);
            end
            if (stall_cycles !== e.st) begin
                errors++;
                $display("FAIL %s stall_cycles: got %0d want %0d", e.nm, stall_cycles, e.st);
            end
            if (flush_count !== e.fl) begin
                errors++;
                $display("FAIL %s flush_count: got %0d want %0d", e.nm, flush_count, e.fl);
            end
            $display("txn %0d %s ctrl=%b fault=%b stall=%0d flush=%0d",
                     txn, e.nm, act, mem_fault, stall_cycles, flush_count);
            txn++;
        end
    end

    task automatic set_idle();
        rstn = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_memread = 1'b0; ex_rd = 5'd0; mem_branch_taken = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    // Loads x5 in EX while the ID instruction reads x5 through rs2.
    task automatic set_lu_match();
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
        id_rs1 = 5'd3; id_use_rs1 = 1'b1;
    endtask

    task automatic exp_cyc(input string nm, input logic [7:0] c, input logic f,
                           input logic [CW-1:0] s, input logic [CW-1:0] fl);
        exp_t e;
        e.nm = nm; e.ctrl = c; e.flt = f; e.st = s; e.fl = fl;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        exp_cyc("reset", C_RST, 1'b0, 4'd0, 4'd0);
        set_idle();
        exp_cyc("idle", C_RUN, 1'b0, 4'd0, 4'd0);

        // load-use on rs2: exactly one stall cycle
        set_lu_match();
        exp_cyc("lu_stall", C_LU, 1'b0, 4'd0, 4'd0);
        ex_memread = 1'b0;
        exp_cyc("lu_after", C_RUN, 1'b0, 4'd1, 4'd0);

        // x0 destination never interlocks
        set_idle();
        ex_memread = 1'b1; ex_rd = 5'd0; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        exp_cyc("lu_x0", C_RUN, 1'b0, 4'd1, 4'd0);

        // taken branch overrides a coincident load-use
        set_idle();
        ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
        mem_branch_taken = 1'b1;
        exp_cyc("branch", C_BR, 1'b0, 4'd1, 4'd0);
        set_idle();
        exp_cyc("br_after", C_RUN, 1'b0, 4'd1, 4'd1);

        // four-cycle memory wait with branch and load-use pending, release applies the branch
        set_idle();
        set_lu_match();
        dmem_req = 1'b1; mem_branch_taken = 1'b1;
        for (int i = 0; i < 4; i++)
            exp_cyc("mem_wait", C_FRZ, 1'b0, CW'(1 + i), 4'd1);
        dmem_ready = 1'b1;
        exp_cyc("release_br", C_BR, 1'b0, 4'd5, 4'd1);

        // ready in the same cycle as the request: no freeze, load-use still applies
        mem_branch_taken = 1'b0;
        exp_cyc("req_ready_lu", C_LU, 1'b0, 4'd5, 4'd2);
        set_idle();
        exp_cyc("back_run", C_RUN, 1'b0, 4'd6, 4'd2);

        // reset while waiting with wait_cnt=3
        dmem_req = 1'b1;
        for (int i = 0; i < 3; i++)
            exp_cyc("wait_pre_rst", C_FRZ, 1'b0, CW'(6 + i), 4'd2);
        rstn = 1'b0;
        exp_cyc("rst_in_wait", C_RST, 1'b0, 4'd9, 4'd2);
        set_idle();
        exp_cyc("post_rst", C_RUN, 1'b0, 4'd0, 4'd0);

        // timeout: one RUN freeze cycle plus 15 MEM_WAIT cycles, stall counter saturates at 15
        dmem_req = 1'b1;
        for (int i = 0; i < 16; i++)
            exp_cyc("timeout_wait", C_FRZ, 1'b0, CW'(i), 4'd0);
        set_lu_match();
        mem_branch_taken = 1'b1;
        for (int i = 0; i < 100; i++) begin
            dmem_ready = i[2];
            mem_branch_taken = i[0];
            exp_cyc("fault_hold", C_FLT, 1'b1, 4'd15, 4'd0);
        end
        rstn = 1'b0;
        exp_cyc("fault_rst", C_RST, 1'b1, 4'd15, 4'd0);
        set_idle();
        exp_cyc("fault_clear", C_RUN, 1'b0, 4'd0, 4'd0);
        set_lu_match();
        exp_cyc("lu_after_fault", C_LU, 1'b0, 4'd0, 4'd0);
        set_idle();
        exp_cyc("final_idle", C_RUN, 1'b0, 4'd1, 4'd0);

        repeat (2) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
